// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bundle between fetch, decode and execute.
interface decode_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           inst;
  logic [DATA_W-1:0]     pc_plus4;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] d_rs;
  logic [REG_ADDR_W-1:0] d_rt;
  logic [REG_ADDR_W-1:0] d_dest;
  logic [DATA_W-1:0]     d_imm;
  logic [25:0]           d_jtarget;
  logic [DATA_W-1:0]     d_pc_plus4;
  logic [5:0]            d_alu_op;
  logic                  d_alu_imm;
  logic                  d_jump;
  logic                  d_jump_reg;
  logic                  d_branch;
  logic                  d_load;
  logic                  d_store;
  logic                  d_link;
  logic                  d_write_reg;
  logic                  d_illegal;
  logic [CNT_W-1:0]      stall_count;

  modport slave (
    input  in_valid, inst, pc_plus4, flush, out_ready,
    output in_ready, out_valid, d_rs, d_rt, d_dest, d_imm,
           d_jtarget, d_pc_plus4, d_alu_op, d_alu_imm, d_jump,
           d_jump_reg, d_branch, d_load, d_store, d_link,
           d_write_reg, d_illegal, stall_count
  );

  modport master (
    output in_valid, inst, pc_plus4, flush, out_ready,
    input  in_ready, out_valid, d_rs, d_rt, d_dest, d_imm,
           d_jtarget, d_pc_plus4, d_alu_op, d_alu_imm, d_jump,
           d_jump_reg, d_branch, d_load, d_store, d_link,
           d_write_reg, d_illegal, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// Mini-MIPS decode stage: registered control bundle, load-use
// bubble, flush, and saturating stall counter.
module decode_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] BGT    = 6'h06;
  localparam logic [5:0] BGTE   = 6'h07;
  localparam logic [5:0] JR     = 6'h08;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] BLE    = 6'h16;
  localparam logic [5:0] BLEQ   = 6'h17;
  localparam logic [5:0] BLEU   = 6'h18;
  localparam logic [5:0] BGTU   = 6'h19;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] SLL    = 6'h00;
  localparam logic [5:0] SRL    = 6'h02;
  localparam logic [5:0] SRA    = 6'h03;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     imm;
    logic [25:0]           jt;
    logic [DATA_W-1:0]     pc;
    logic [5:0]            alu_op;
    logic                  alu_imm;
    logic                  jump;
    logic                  jump_reg;
    logic                  branch;
    logic                  load;
    logic                  store;
    logic                  link;
    logic                  write_reg;
    logic                  illegal;
  } bundle_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_r, is_j, is_jal, is_jr, is_br;
  logic        is_lui, is_lw, is_sw, legal;
  logic        shift, uses_rs, uses_rt;
  logic        hazard, accept, stall_inc;
  logic [31:0] lui_val;
  bundle_t     dec;
  bundle_t     bun_q, bun_d;
  logic        valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op      = bus.inst[31:26];
  assign funct   = bus.inst[5:0];
  assign lui_val = {bus.inst[15:0], 16'b0};

  always_comb begin
    is_r   = 1'b0;
    is_j   = 1'b0;
    is_jal = 1'b0;
    is_jr  = 1'b0;
    is_br  = 1'b0;
    is_lui = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    legal  = 1'b1;
    case (op)
      R_TYPE: is_r   = 1'b1;
      J:      is_j   = 1'b1;
      JAL:    is_jal = 1'b1;
      JR:     is_jr  = 1'b1;
      LUI:    is_lui = 1'b1;
      LW:     is_lw  = 1'b1;
      SW:     is_sw  = 1'b1;
      BEQ, BNE, BGT, BGTE,
      BLE, BLEQ, BLEU, BGTU:
              is_br  = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign shift = is_r &&
    (funct == SLL || funct == SRL || funct == SRA);
  assign uses_rs = !(is_j || is_jal);
  assign uses_rt = is_r || is_sw || is_br;

  always_comb begin
    dec          = '0;
    dec.rs       = bus.inst[25:21];
    dec.rt       = bus.inst[20:16];
    dec.jt       = bus.inst[25:0];
    dec.pc       = bus.pc_plus4;
    dec.alu_op   = funct;
    dec.jump     = is_j || is_jr || is_jal;
    dec.jump_reg = is_jr;
    dec.link     = is_jal;
    dec.branch   = is_br;
    dec.load     = is_lw || is_lui;
    dec.store    = is_sw;
    dec.illegal  = !legal;
    dec.alu_imm  = is_r ? shift : !is_br;
    if (is_jal)
      dec.dest = REG_ADDR_W'(LINK_REG);
    else if (is_r)
      dec.dest = bus.inst[15:11];
    else
      dec.dest = bus.inst[20:16];
    if (shift)
      dec.imm = DATA_W'(bus.inst[10:6]);
    else if (is_lui)
      dec.imm = DATA_W'(lui_val);
    else
      dec.imm = DATA_W'($signed(bus.inst[15:0]));
    dec.write_reg = legal && (is_r || is_jal || dec.load) &&
                    dec.dest != '0;
  end

  // Only a valid load still sitting in the output register can
  // leave its result unavailable to the next instruction.
  assign hazard = valid_q && bun_q.load && bun_q.dest != '0 &&
    ((uses_rs && bus.inst[25:21] == bun_q.dest) ||
     (uses_rt && bus.inst[20:16] == bun_q.dest));

  assign bus.in_ready = (!valid_q || bus.out_ready) &&
                        !hazard && !bus.flush;
  assign accept    = bus.in_valid && bus.in_ready;
  assign stall_inc = bus.in_valid && hazard &&
                     bus.out_ready && !bus.flush;

  always_comb begin
    valid_d = valid_q;
    bun_d   = bun_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      bun_d   = dec;
    end else if (bus.out_ready && valid_q) begin
      valid_d = 1'b0;
    end
    if (stall_inc && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bun_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bun_q   <= bun_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.d_rs        = bun_q.rs;
  assign bus.d_rt        = bun_q.rt;
  assign bus.d_dest      = bun_q.dest;
  assign bus.d_imm       = bun_q.imm;
  assign bus.d_jtarget   = bun_q.jt;
  assign bus.d_pc_plus4  = bun_q.pc;
  assign bus.d_alu_op    = bun_q.alu_op;
  assign bus.d_alu_imm   = bun_q.alu_imm;
  assign bus.d_jump      = bun_q.jump;
  assign bus.d_jump_reg  = bun_q.jump_reg;
  assign bus.d_branch    = bun_q.branch;
  assign bus.d_load      = bun_q.load;
  assign bus.d_store     = bun_q.store;
  assign bus.d_link      = bun_q.link;
  assign bus.d_write_reg = bun_q.write_reg;
  assign bus.d_illegal   = bun_q.illegal;
  assign bus.stall_count = cnt_q;
endmodule
